// File: rtl/sa_input_skew_pkg.sv
// Shared definitions for the activation skew stage: job FSM encoding,
// delay-line slice sizing and drain counter sizing.
package sa_input_skew_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    // Each delay-line slice carries one valid bit above the lane data.
    localparam int unsigned LANE_VALID_W = 1;

    function automatic int unsigned lane_slice_w(input int unsigned data_width);
        return data_width + LANE_VALID_W;
    endfunction

    function automatic int unsigned drain_cnt_w(input int unsigned pe_size);
        return (pe_size > 1) ? $clog2(pe_size) : 1;
    endfunction

endpackage

// File: rtl/sa_input_skew_delay_line.sv
// Fixed-depth shift register with synchronous active-low reset and a
// global enable; used as one skew lane of the activation wavefront.
module skew_delay_line #(
    parameter int unsigned DEPTH = 1,
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else if (en) begin
            stage[0] <= d;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[DEPTH-1];

endmodule

// File: rtl/sa_input_skew.sv
// Skews GLB activation vectors into a diagonal wavefront (lane k delayed
// k+1 cycles) and runs the IDLE/RUN/DRAIN job FSM that reports completion.
module sa_input_skew
    import sa_input_skew_pkg::*;
#(
    parameter int unsigned PE_SIZE    = 16,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic [PE_SIZE*DATA_WIDTH-1:0] data_i,
    input  logic                          valid_i,
    input  logic                          last_i,
    output logic                          ready_o,
    output logic [PE_SIZE*DATA_WIDTH-1:0] data_o,
    output logic [PE_SIZE-1:0]            valid_o,
    output logic                          busy_o,
    output logic                          done_o
);

    localparam int unsigned SLICE_W = lane_slice_w(DATA_WIDTH);
    localparam int unsigned CNT_W   = drain_cnt_w(PE_SIZE);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PE_SIZE - 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             acc;

    assign ready_o = (state == ST_IDLE) || (state == ST_RUN);
    assign busy_o  = (state != ST_IDLE);
    assign acc     = en & valid_i & ready_o;

    genvar k;
    generate
        for (k = 0; k < PE_SIZE; k++) begin : g_lane
            logic [DATA_WIDTH-1:0] lane_in;
            logic [SLICE_W-1:0]    lane_q;

            // Non-accepted cycles enter the line as all-zero bubbles.
            assign lane_in = acc ? data_i[k*DATA_WIDTH +: DATA_WIDTH] : '0;

            skew_delay_line #(
                .DEPTH (k + 1),
                .WIDTH (SLICE_W)
            ) u_line (
                .clk   (clk),
                .rst_n (rst_n),
                .en    (en),
                .d     ({acc, lane_in}),
                .q     (lane_q)
            );

            assign valid_o[k]                          = lane_q[SLICE_W-1];
            assign data_o[k*DATA_WIDTH +: DATA_WIDTH]  = lane_q[DATA_WIDTH-1:0];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            done_o <= 1'b0;
        end else if (en) begin
            done_o <= 1'b0;
            case (state)
                ST_IDLE, ST_RUN: begin
                    if (acc) begin
                        if (last_i) begin
                            state <= ST_DRAIN;
                            cnt   <= CNT_LOAD;
                        end else begin
                            state <= ST_RUN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        state  <= ST_IDLE;
                        done_o <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sa_input_skew.sv
// Self-checking bench for sa_input_skew: table-driven job sequences plus
// hand-written stall, backpressure and mid-drain reset sequences.
module tb_sa_input_skew;
    import sa_input_skew_pkg::*;

    localparam int unsigned PE = 16;
    localparam int unsigned DW = 8;
    localparam int unsigned VW = PE * DW;
    localparam int unsigned CW = VW + PE + 3;

    logic          clk = 1'b0;
    logic          rst_n, en, valid_i, last_i;
    logic          ready_o, busy_o, done_o;
    logic [VW-1:0] data_i, data_o;
    logic [PE-1:0] valid_o;

    sa_input_skew #(
        .PE_SIZE    (PE),
        .DATA_WIDTH (DW)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .data_i  (data_i),
        .valid_i (valid_i),
        .last_i  (last_i),
        .ready_o (ready_o),
        .data_o  (data_o),
        .valid_o (valid_o),
        .busy_o  (busy_o),
        .done_o  (done_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            e;
        logic [VW-1:0] d;
    } acc_t;

    typedef struct {
        logic          vld;
        logic          lst;
        logic [VW-1:0] d;
        logic          acc;
        logic          busy;
        logic          ready;
    } vec_t;

    acc_t acc_q[$];
    int   done_q[$];
    vec_t tbl[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   ecyc     = 0;

    task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [VW-1:0] fill(input logic [DW-1:0] b);
        logic [VW-1:0] v;
        for (int k = 0; k < PE; k++) v[k*DW +: DW] = b;
        return v;
    endfunction

    function automatic logic [VW-1:0] lanes_inc();
        logic [VW-1:0] v;
        for (int k = 0; k < PE; k++) v[k*DW +: DW] = DW'(k + 1);
        return v;
    endfunction

    // Expected lane k output in enabled cycle c is the vector accepted in c-k-1.
    task automatic scoreboard();
        logic ev_done;
        for (int k = 0; k < PE; k++) begin
            logic          ev;
            logic [DW-1:0] ed;
            ev = 1'b0;
            ed = '0;
            foreach (acc_q[i]) begin
                if (acc_q[i].e + k + 1 == ecyc) begin
                    ev = 1'b1;
                    ed = acc_q[i].d[k*DW +: DW];
                end
            end
            chk($sformatf("valid lane%0d ecyc%0d", k, ecyc), CW'(valid_o[k]), CW'(ev));
            chk($sformatf("data lane%0d ecyc%0d", k, ecyc), CW'(data_o[k*DW +: DW]), CW'(ed));
        end
        while (acc_q.size() > 0 && acc_q[0].e + int'(PE) <= ecyc) void'(acc_q.pop_front());
        ev_done = (done_q.size() > 0) && (done_q[0] == ecyc);
        chk($sformatf("done ecyc%0d", ecyc), CW'(done_o), CW'(ev_done));
        if (ev_done) void'(done_q.pop_front());
        while (done_q.size() > 0 && done_q[0] < ecyc) void'(done_q.pop_front());
    endtask

    task automatic tick();
        logic          was_en;
        logic [CW-1:0] snap;
        was_en = en;
        snap   = {data_o, valid_o, done_o, busy_o, ready_o};
        @(posedge clk);
        #1;
        cyc++;
        if (was_en) begin
            ecyc++;
            scoreboard();
        end else begin
            chk($sformatf("frozen outputs cyc%0d", cyc),
                {data_o, valid_o, done_o, busy_o, ready_o}, snap);
        end
    endtask

    task automatic drive(input logic vld, input logic lst, input logic [VW-1:0] d, input logic acc);
        valid_i = vld;
        last_i  = lst;
        data_i  = d;
        if (acc) begin
            acc_q.push_back('{e: ecyc, d: d});
            if (lst) done_q.push_back(ecyc + int'(PE) + 1);
        end
    endtask

    task automatic wait_done(input int max_cycles, output int at);
        bit seen;
        seen = 1'b0;
        at   = -1;
        drive(1'b0, 1'b0, '0, 1'b0);
        for (int i = 0; i < max_cycles && !seen; i++) begin
            tick();
            if (done_o) begin
                seen = 1'b1;
                at   = cyc;
            end
        end
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL done wait: no done_o within %0d cycles", max_cycles);
        end
    endtask

    task automatic add(input logic vld, input logic lst, input logic [VW-1:0] d,
                       input logic acc, input logic busy, input logic ready);
        vec_t r;
        r.vld = vld; r.lst = lst; r.d = d; r.acc = acc; r.busy = busy; r.ready = ready;
        tbl.push_back(r);
    endtask

    // Fifteen DRAIN cycles with junk on data_i, then the done cycle and one spacer.
    task automatic add_drain();
        for (int i = 0; i < 15; i++) add(1'b0, 1'b0, fill(8'h5A), 1'b0, 1'b1, 1'b0);
        add(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        add(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        int t0, t_done, n_done;

        rst_n = 1'b0; en = 1'b1; valid_i = 1'b0; last_i = 1'b0; data_i = '0;
        tick();
        tick();
        chk("reset data_o",  CW'(data_o),  '0);
        chk("reset valid_o", CW'(valid_o), '0);
        chk("reset done_o",  CW'(done_o),  '0);
        chk("reset busy_o",  CW'(busy_o),  '0);
        chk("reset ready_o", CW'(ready_o), CW'(1));
        rst_n = 1'b1;

        // Single vector, lanes 0x01..0x10
        add(1'b1, 1'b1, lanes_inc(), 1'b1, 1'b1, 1'b0);
        add_drain();
        // Four back-to-back vectors 0xA0..0xA3
        add(1'b1, 1'b0, fill(8'hA0), 1'b1, 1'b1, 1'b1);
        add(1'b1, 1'b0, fill(8'hA1), 1'b1, 1'b1, 1'b1);
        add(1'b1, 1'b0, fill(8'hA2), 1'b1, 1'b1, 1'b1);
        add(1'b1, 1'b1, fill(8'hA3), 1'b1, 1'b1, 1'b0);
        add_drain();
        // Bubble in the middle of a job
        add(1'b1, 1'b0, fill(8'h30), 1'b1, 1'b1, 1'b1);
        add(1'b0, 1'b0, fill(8'h55), 1'b0, 1'b1, 1'b1);
        add(1'b1, 1'b1, fill(8'h32), 1'b1, 1'b1, 1'b0);
        add_drain();

        foreach (tbl[i]) begin
            drive(tbl[i].vld, tbl[i].lst, tbl[i].d, tbl[i].acc);
            tick();
            chk($sformatf("busy row%0d", i),  CW'(busy_o),  CW'(tbl[i].busy));
            chk($sformatf("ready row%0d", i), CW'(ready_o), CW'(tbl[i].ready));
        end

        // Stall for three cycles in DRAIN with cnt=7
        t0 = cyc;
        drive(1'b1, 1'b1, fill(8'h60), 1'b1);
        tick();
        drive(1'b0, 1'b0, '0, 1'b0);
        repeat (8) tick();
        chk("stall cnt before", CW'(dut.cnt), CW'(7));
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("stall cnt %0d", i),   CW'(dut.cnt),   CW'(7));
            chk($sformatf("stall state %0d", i), CW'(dut.state), CW'(ST_DRAIN));
        end
        en = 1'b1;
        wait_done(30, t_done);
        chk("stall done delay", CW'(t_done - t0), CW'(PE + 1 + 3));
        en = 1'b0;
        tick();
        chk("done held while stalled", CW'(done_o), CW'(1));
        en = 1'b1;
        tick();

        // Backpressure during DRAIN, then accept in the done cycle
        drive(1'b1, 1'b1, fill(8'h70), 1'b1);
        tick();
        chk("drain ready_o", CW'(ready_o), '0);
        for (int i = 1; i <= 16; i++) begin
            drive(1'b1, 1'b1, fill(8'hFF), 1'b0);
            tick();
        end
        chk("bp done_o", CW'(done_o), CW'(1));
        chk("bp ready in done cycle", CW'(ready_o), CW'(1));
        drive(1'b1, 1'b0, fill(8'h71), 1'b1);
        tick();
        chk("bp lane0 valid", CW'(valid_o[0]), CW'(1));
        chk("bp lane0 data", CW'(data_o[DW-1:0]), CW'(8'h71));
        drive(1'b1, 1'b1, fill(8'h72), 1'b1);
        tick();
        wait_done(30, t_done);
        tick();

        // Reset at t+5 of a drain
        drive(1'b1, 1'b1, fill(8'h80), 1'b1);
        tick();
        drive(1'b0, 1'b0, '0, 1'b0);
        repeat (4) tick();
        acc_q.delete();
        done_q.delete();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mid reset valid_o", CW'(valid_o), '0);
        chk("mid reset data_o",  CW'(data_o),  '0);
        chk("mid reset busy_o",  CW'(busy_o),  '0);
        chk("mid reset ready_o", CW'(ready_o), CW'(1));
        n_done = 0;
        repeat (24) begin
            tick();
            if (done_o) n_done++;
        end
        chk("no done after reset", CW'(n_done), '0);

        chk("acc queue drained",  CW'(acc_q.size()),  '0);
        chk("done queue drained", CW'(done_q.size()), '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
